// File: rtl/an_code_pkg.sv
// Shared constants, FSM state encoding and a width helper for the AN-code
// single-error-correcting decoder.
package an_code_pkg;

    localparam int DEF_A       = 6311;
    localparam int DEF_N_WIDTH = 20;
    localparam int DEF_A_WIDTH = 13;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DIV1   = 3'd1,
        ST_SEARCH = 3'd2,
        ST_DIV2   = 3'd3,
        ST_DONE   = 3'd4
    } state_e;

    // Number of bits needed to represent a non-negative value (at least 1).
    function automatic int bits_for(input longint value);
        int     b = 0;
        longint v = value;
        while (v > 0) begin
            b++;
            v = v >> 1;
        end
        return (b == 0) ? 1 : b;
    endfunction

endpackage

// File: rtl/an_seq_divider.sv
// Restoring radix-2 divider by the constant A: W_WIDTH steps, the first one
// taken on the start cycle directly from the dividend input.
module an_seq_divider
    import an_code_pkg::*;
#(
    parameter int W_WIDTH = 33,
    parameter int A       = DEF_A,
    parameter int A_WIDTH = DEF_A_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [W_WIDTH-1:0] dividend,
    output logic               busy,
    output logic               done,
    output logic [W_WIDTH-1:0] quotient,
    output logic [A_WIDTH-1:0] remainder
);

    localparam int               CNT_W = $clog2(W_WIDTH + 1);
    localparam logic [A_WIDTH:0] A_EXT = (A_WIDTH + 1)'(A);

    logic [W_WIDTH-1:0] quo_q, quo_d;
    logic [A_WIDTH-1:0] rem_q, rem_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               load;
    logic [A_WIDTH-1:0] step_rem_in;
    logic [W_WIDTH-1:0] step_quo_in;
    logic [A_WIDTH:0]   trial;
    logic               take;
    logic [A_WIDTH-1:0] step_rem;
    logic [W_WIDTH-1:0] step_quo;

    always_comb begin
        load        = start && !busy_q;
        step_rem_in = load ? '0 : rem_q;
        step_quo_in = load ? dividend : quo_q;
        // Quotient bits shift in at the bottom while dividend bits leave the top.
        trial       = {step_rem_in, step_quo_in[W_WIDTH-1]};
        take        = (trial >= A_EXT);
        step_rem    = take ? A_WIDTH'(trial - A_EXT) : trial[A_WIDTH-1:0];
        step_quo    = {step_quo_in[W_WIDTH-2:0], take};

        quo_d  = quo_q;
        rem_d  = rem_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        done_d = 1'b0;
        if (load) begin
            quo_d  = step_quo;
            rem_d  = step_rem;
            cnt_d  = CNT_W'(W_WIDTH - 1);
            busy_d = 1'b1;
        end else if (busy_q) begin
            quo_d = step_quo;
            rem_d = step_rem;
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            quo_q  <= '0;
            rem_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            quo_q  <= quo_d;
            rem_q  <= rem_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign quotient  = quo_q;
    assign remainder = rem_q;

endmodule

// File: rtl/an_sec_decoder_seq.sv
// Sequential AN-code decoder: divides by A, and on a nonzero remainder searches
// for a single +/-2^i arithmetic error, removes it and divides again.
module an_sec_decoder_seq
    import an_code_pkg::*;
#(
    parameter int N_WIDTH = DEF_N_WIDTH,
    parameter int A       = DEF_A,
    parameter int A_WIDTH = DEF_A_WIDTH,
    parameter int W_WIDTH = N_WIDTH + A_WIDTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [W_WIDTH-1:0]         in_w,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [N_WIDTH-1:0]         out_n,
    output logic                       out_corrected,
    output logic                       out_uncorrectable,
    output logic [$clog2(W_WIDTH)-1:0] out_err_pos,
    output logic                       out_err_neg,
    output logic [2:0]                 dbg_state
);

    localparam int                 POS_W = $clog2(W_WIDTH);
    localparam logic [A_WIDTH-1:0] A_VAL = A_WIDTH'(A);
    localparam logic [A_WIDTH:0]   A_EXT = (A_WIDTH + 1)'(A);

    if ((A % 2) == 0 || A <= 2 || bits_for(A - 1) > A_WIDTH) begin : g_bad_params
        $error("an_sec_decoder_seq: A must be odd, greater than 2, and A-1 must fit in A_WIDTH");
    end

    state_e             state_q, state_d;
    logic               arm_q, arm_d;
    logic [W_WIDTH-1:0] w_q, w_d;
    logic [N_WIDTH-1:0] q1_q, q1_d;
    logic [A_WIDTH-1:0] r_q, r_d, p_q, p_d;
    logic [POS_W-1:0]   i_q, i_d;
    logic               neg_q, neg_d, bad_q, bad_d;
    logic [N_WIDTH-1:0] res_n_q, res_n_d;
    logic               res_corr_q, res_corr_d, res_unc_q, res_unc_d;
    logic [POS_W-1:0]   res_pos_q, res_pos_d;
    logic               res_neg_q, res_neg_d;

    logic               div_start, div_busy, div_done;
    logic [W_WIDTH-1:0] div_dividend, div_quo;
    logic [A_WIDTH-1:0] div_rem;

    logic [A_WIDTH-1:0] a_minus_p, p_next;
    logic [A_WIDTH:0]   p_dbl;
    logic               hit_pos, hit_neg;
    logic [W_WIDTH:0]   delta, w_prime;

    an_seq_divider #(
        .W_WIDTH(W_WIDTH),
        .A      (A),
        .A_WIDTH(A_WIDTH)
    ) u_div (
        .clk      (clk),
        .rst      (rst),
        .start    (div_start),
        .dividend (div_dividend),
        .busy     (div_busy),
        .done     (div_done),
        .quotient (div_quo),
        .remainder(div_rem)
    );

    always_comb begin
        a_minus_p = A_VAL - p_q;
        hit_pos   = (r_q == p_q);
        hit_neg   = (r_q == a_minus_p);
        delta     = (W_WIDTH + 1)'(1) << i_q;
        // One extra bit: a set MSB means W' went negative or reached 2^W_WIDTH.
        w_prime   = hit_pos ? ({1'b0, w_q} - delta) : ({1'b0, w_q} + delta);
        p_dbl     = {p_q, 1'b0};
        p_next    = (p_dbl >= A_EXT) ? A_WIDTH'(p_dbl - A_EXT) : p_dbl[A_WIDTH-1:0];

        state_d      = state_q;
        arm_d        = 1'b1;
        w_d          = w_q;
        q1_d         = q1_q;
        r_d          = r_q;
        p_d          = p_q;
        i_d          = i_q;
        neg_d        = neg_q;
        bad_d        = bad_q;
        res_n_d      = res_n_q;
        res_corr_d   = res_corr_q;
        res_unc_d    = res_unc_q;
        res_pos_d    = res_pos_q;
        res_neg_d    = res_neg_q;
        div_start    = 1'b0;
        div_dividend = w_q;

        case (state_q)
            ST_IDLE: begin
                if (in_valid && in_ready) begin
                    w_d     = in_w;
                    state_d = ST_DIV1;
                end
            end
            ST_DIV1: begin
                div_start = !div_busy && !div_done;
                if (div_done) begin
                    res_n_d    = div_quo[N_WIDTH-1:0];
                    res_corr_d = 1'b0;
                    res_unc_d  = 1'b0;
                    res_pos_d  = '0;
                    res_neg_d  = 1'b0;
                    if (div_rem == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        q1_d    = div_quo[N_WIDTH-1:0];
                        r_d     = div_rem;
                        p_d     = A_WIDTH'(1);
                        i_d     = '0;
                        state_d = ST_SEARCH;
                    end
                end
            end
            ST_SEARCH: begin
                if (hit_pos || hit_neg) begin
                    neg_d        = !hit_pos;
                    bad_d        = w_prime[W_WIDTH];
                    div_start    = 1'b1;
                    div_dividend = w_prime[W_WIDTH-1:0];
                    state_d      = ST_DIV2;
                end else if (i_q == POS_W'(W_WIDTH - 1)) begin
                    res_unc_d = 1'b1;
                    state_d   = ST_DONE;
                end else begin
                    i_d = i_q + POS_W'(1);
                    p_d = p_next;
                end
            end
            ST_DIV2: begin
                if (div_done) begin
                    if (bad_q || div_rem != '0 || div_quo[W_WIDTH-1:N_WIDTH] != '0) begin
                        res_unc_d = 1'b1;
                    end else begin
                        res_n_d    = div_quo[N_WIDTH-1:0];
                        res_corr_d = 1'b1;
                        res_pos_d  = i_q;
                        res_neg_d  = neg_q;
                    end
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            arm_q      <= 1'b0;
            w_q        <= '0;
            q1_q       <= '0;
            r_q        <= '0;
            p_q        <= '0;
            i_q        <= '0;
            neg_q      <= 1'b0;
            bad_q      <= 1'b0;
            res_n_q    <= '0;
            res_corr_q <= 1'b0;
            res_unc_q  <= 1'b0;
            res_pos_q  <= '0;
            res_neg_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            arm_q      <= arm_d;
            w_q        <= w_d;
            q1_q       <= q1_d;
            r_q        <= r_d;
            p_q        <= p_d;
            i_q        <= i_d;
            neg_q      <= neg_d;
            bad_q      <= bad_d;
            res_n_q    <= res_n_d;
            res_corr_q <= res_corr_d;
            res_unc_q  <= res_unc_d;
            res_pos_q  <= res_pos_d;
            res_neg_q  <= res_neg_d;
        end
    end

    // Handshakes: a word moves on any cycle where valid and ready are both high
    // at the rising edge; result fields read zero unless out_valid is high.
    assign in_ready          = (state_q == ST_IDLE) && arm_q;
    assign out_valid         = (state_q == ST_DONE);
    assign out_n             = out_valid ? res_n_q : '0;
    assign out_corrected     = out_valid && res_corr_q;
    assign out_uncorrectable = out_valid && res_unc_q;
    assign out_err_pos       = out_valid ? res_pos_q : '0;
    assign out_err_neg       = out_valid && res_neg_q;
    assign dbg_state         = state_q;

endmodule

// File: doc/an_sec_decoder_seq.md
AN_SEC_DECODER_SEQ -- requirements
Module: an_sec_decoder_seq

Interface
REQ-001 Parameter N_WIDTH, default 20: data word width; the decoded N is N_WIDTH bits.
REQ-002 Parameter A, default 6311: AN-code multiplier; odd, greater than 2.
REQ-003 Parameter A_WIDTH, default 13: bits needed to hold A-1.
REQ-004 Parameter W_WIDTH, default N_WIDTH+A_WIDTH (33): codeword width.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 in_valid  input  1  codeword W is valid.
REQ-008 in_ready  output  1  decoder can accept W.
REQ-009 in_w  input  W_WIDTH  received codeword W = A*N + e, unsigned.
REQ-010 out_valid  output  1  result fields valid.
REQ-011 out_ready  input  1  consumer accepts the result.
REQ-012 out_n  output  N_WIDTH  decoded N.
REQ-013 out_corrected  output  1  a single arithmetic-weight error was found and removed.
REQ-014 out_uncorrectable  output  1  nonzero syndrome with no legal correction.
REQ-015 out_err_pos  output  $clog2(W_WIDTH)  bit index i of the corrected error.
REQ-016 out_err_neg  output  1  1 when the error was -2^i, 0 when +2^i.

Function
REQ-017 The FSM states are IDLE, DIV1, SEARCH, DIV2 and DONE.
REQ-018 in_ready is 1 only in IDLE; in_valid and in_ready both high in one cycle latch in_w and enter DIV1.
REQ-019 DIV1 is a restoring radix-2 divider that runs exactly W_WIDTH cycles and produces Q = floor(W/A) and R = W mod A.
REQ-020 If R equals 0, the FSM goes to DONE with out_n = Q[N_WIDTH-1:0] and all error flags at 0.
REQ-021 If R is nonzero, SEARCH scans i = 0 to W_WIDTH-1, one i per cycle, keeping p = 2^i mod A with p(0) = 1 and p(i+1) = 2p mod A, so no ROM is used.
REQ-022 At each i, SEARCH tests R == p (delta = +2^i) before R == A-p (delta = -2^i); the first match stops the scan.
REQ-023 If no i matches, the FSM goes to DONE with out_uncorrectable = 1, out_corrected = 0 and out_n = Q[N_WIDTH-1:0].
REQ-024 On a match, the FSM forms W' = W - delta in W_WIDTH+1 bits.
REQ-025 If W' is negative, or W' is at least 2^W_WIDTH, the FSM goes to DONE with out_uncorrectable = 1 and out_n = Q[N_WIDTH-1:0].
REQ-026 Otherwise DIV2 reuses the divider for W_WIDTH cycles to compute N = W'/A.
REQ-027 DIV2 asserts out_uncorrectable instead of out_corrected if the remainder is nonzero or the quotient exceeds N_WIDTH bits.
REQ-028 After a successful DIV2, the FSM goes to DONE with out_corrected = 1, out_err_pos = i and out_err_neg set to the delta sign.
REQ-029 In DONE, out_valid = 1 and every out_* field is held stable until out_valid and out_ready are both high; the FSM then returns to IDLE.
REQ-030 There is no overlap between words: a new input is accepted no earlier than the cycle after the output handshake.
REQ-031 Latency from the accept cycle to the first out_valid cycle:
- R = 0: W_WIDTH+1 cycles.
- Match at index k: 2*W_WIDTH+k+2 cycles.
- No match: 2*W_WIDTH+1 cycles.
REQ-032 out_corrected and out_uncorrectable are never both 1.
REQ-033 out_n, out_err_pos and the error flags read 0 whenever out_valid = 0.

Reset
REQ-034 rst = 1 forces IDLE immediately, independent of clk.
REQ-035 During rst, in_ready = 0, out_valid = 0 and all out_* fields = 0.
REQ-036 in_ready = 1 on the first clk edge after rst deasserts.
REQ-037 Reset during DIV1, SEARCH, DIV2 or DONE discards the word in flight; no result for it is ever presented.

Structure
REQ-038 Package an_code_pkg holds the FSM state enum, the default A/N_WIDTH/A_WIDTH constants and a constant function giving the bit width of a value.
REQ-039 The divider is the sub-module an_seq_divider (start/busy/done, dividend, quotient, remainder), shared by DIV1 and DIV2.
REQ-040 Elaboration fails if A is even or if A-1 does not fit in A_WIDTH.

Verification
All scenarios use the default parameters (A = 6311, N_WIDTH = 20, W_WIDTH = 33).
REQ-041 in_w = 6311000 -> out_n = 1000, both flags 0, out_valid after 34 cycles.
REQ-042 in_w = 6311008 (+2^3) -> out_n = 1000, out_corrected = 1, out_err_pos = 3, out_err_neg = 0.
REQ-043 in_w = 6302808 (-2^13, R = 4430) -> out_n = 1000, out_corrected = 1, out_err_pos = 13, out_err_neg = 1.
REQ-044 in_w = 6311003 (R = 3) -> out_uncorrectable = 1, out_corrected = 0, out_n = 1000.
REQ-045 Hold out_ready low for 5 cycles in DONE -> all outputs stable and in_ready = 0; release -> handshake completes and in_ready = 1 on the next cycle.
REQ-046 Assert rst mid-DIV2, then decode in_w = 0 -> out_n = 0, flags 0, and no stale result appears.
